// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state encoding and ratio constants for the clock divider
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } div_state_t;

    localparam int MIN_DIV_RATIO = 2;
    localparam int BYPASS_RATIO  = 1;

endpackage

// File: rtl/clk_bypass_mux.sv
// rtl/clk_bypass_mux.sv - 2:1 clock mux selecting the divided clock or the reference clock
module clk_bypass_mux (
    input  logic clk,
    input  logic div_q,
    input  logic sel,
    output logic clk_out
);

    // Kept as its own cell boundary so it can be mapped to a dedicated clock mux.
    assign clk_out = sel ? div_q : clk;

endmodule

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - integer clock divider with boundary-aligned ratio changes and bypass
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CLK_EN,
    input  logic [DATA_WIDTH-1:0] DIV_RATIO,
    output logic                  DIV_CLK,
    output logic                  DIV_ACTIVE,
    output logic                  PERIOD_TICK
);

    div_state_t            state;
    logic [DATA_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] ratio_q;
    logic                  div_q;
    logic [DATA_WIDTH-1:0] low_len;
    logic [DATA_WIDTH-1:0] high_len;
    logic                  start_req;

    assign start_req = CLK_EN && (DIV_RATIO >= DATA_WIDTH'(MIN_DIV_RATIO));
    // Odd ratios put the extra cycle in the high phase.
    assign low_len   = ratio_q >> 1;
    assign high_len  = ratio_q - low_len;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ratio_q     <= DATA_WIDTH'(BYPASS_RATIO);
            div_q       <= 1'b0;
            DIV_ACTIVE  <= 1'b0;
            PERIOD_TICK <= 1'b0;
        end else begin
            PERIOD_TICK <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt   <= '0;
                    div_q <= 1'b0;
                    if (start_req) begin
                        state      <= ST_LOW;
                        ratio_q    <= DIV_RATIO;
                        DIV_ACTIVE <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (cnt == low_len - DATA_WIDTH'(1)) begin
                        state <= ST_HIGH;
                        cnt   <= '0;
                        div_q <= 1'b1;
                    end else begin
                        cnt <= cnt + DATA_WIDTH'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt == high_len - DATA_WIDTH'(1)) begin
                        cnt   <= '0;
                        div_q <= 1'b0;
                        if (start_req) begin
                            state       <= ST_LOW;
                            ratio_q     <= DIV_RATIO;
                            PERIOD_TICK <= 1'b1;
                        end else begin
                            state      <= ST_IDLE;
                            DIV_ACTIVE <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + DATA_WIDTH'(1);
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    cnt        <= '0;
                    div_q      <= 1'b0;
                    DIV_ACTIVE <= 1'b0;
                end
            endcase
        end
    end

    clk_bypass_mux u_mux (
        .clk     (CLK),
        .div_q   (div_q),
        .sel     (DIV_ACTIVE),
        .clk_out (DIV_CLK)
    );

endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - directed self-checking bench for clk_div_gen
module tb_clk_div_gen;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CLK_EN;
    logic [7:0] DIV_RATIO;
    logic       DIV_CLK;
    logic       DIV_ACTIVE;
    logic       PERIOD_TICK;

    int total = 0;
    int bad   = 0;

    clk_div_gen #(.DATA_WIDTH(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .CLK_EN      (CLK_EN),
        .DIV_RATIO   (DIV_RATIO),
        .DIV_CLK     (DIV_CLK),
        .DIV_ACTIVE  (DIV_ACTIVE),
        .PERIOD_TICK (PERIOD_TICK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // n cycles at DIV_CLK level lvl; tick expected only in the first cycle when t0 is set.
    task automatic phase(input string tag, input logic lvl, input int n, input logic t0);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            chk({tag, ".clk"}, DIV_CLK, lvl);
            chk({tag, ".act"}, DIV_ACTIVE, 1'b1);
            chk({tag, ".tick"}, PERIOD_TICK, (i == 0) ? t0 : 1'b0);
        end
    endtask

    task automatic bypass_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            chk({tag, ".act"}, DIV_ACTIVE, 1'b0);
            chk({tag, ".tick"}, PERIOD_TICK, 1'b0);
            chk({tag, ".clk_hi"}, DIV_CLK, 1'b1);
            @(negedge CLK);
            #1;
            chk({tag, ".clk_lo"}, DIV_CLK, 1'b0);
        end
    endtask

    initial begin
        RST       = 1'b1;
        CLK_EN    = 1'b1;
        DIV_RATIO = 8'd4;

        // Reset held with enable and ratio valid
        #2;
        chk("rst.act", DIV_ACTIVE, 1'b0);
        chk("rst.tick", PERIOD_TICK, 1'b0);
        chk("rst.clk_lo", DIV_CLK, 1'b0);
        @(posedge CLK);
        #1;
        chk("rst.clk_hi", DIV_CLK, 1'b1);
        chk("rst.act2", DIV_ACTIVE, 1'b0);
        RST = 1'b0;

        // R=4: 2 low / 2 high
        phase("r4.l0", 1'b0, 2, 1'b0);
        phase("r4.h0", 1'b1, 2, 1'b0);
        phase("r4.l1", 1'b0, 2, 1'b1);
        DIV_RATIO = 8'd3;
        phase("r4.h1", 1'b1, 2, 1'b0);

        // R=3: 1 low / 2 high
        phase("r3.l0", 1'b0, 1, 1'b1);
        phase("r3.h0", 1'b1, 2, 1'b0);
        phase("r3.l1", 1'b0, 1, 1'b1);
        DIV_RATIO = 8'd255;
        phase("r3.h1", 1'b1, 2, 1'b0);

        // R=255: 127 low / 128 high
        phase("r255.l", 1'b0, 127, 1'b1);
        DIV_RATIO = 8'd8;
        phase("r255.h", 1'b1, 128, 1'b0);

        // R=8, then switched to 2 mid-LOW
        phase("r8.l0a", 1'b0, 2, 1'b1);
        DIV_RATIO = 8'd2;
        phase("r8.l0b", 1'b0, 2, 1'b0);
        phase("r8.h0", 1'b1, 4, 1'b0);
        phase("r2.l0", 1'b0, 1, 1'b1);
        phase("r2.h0", 1'b1, 1, 1'b0);
        phase("r2.l1", 1'b0, 1, 1'b1);
        DIV_RATIO = 8'd8;
        phase("r2.h1", 1'b1, 1, 1'b0);

        // R=8, enable dropped 2 cycles into HIGH (with a simultaneous ratio change)
        phase("dis.l", 1'b0, 4, 1'b1);
        phase("dis.ha", 1'b1, 2, 1'b0);
        CLK_EN    = 1'b0;
        DIV_RATIO = 8'd0;
        phase("dis.hb", 1'b1, 2, 1'b0);
        bypass_cycles("dis.idle", 2);

        // Ratios 0 and 1 stay in bypass even when enabled
        CLK_EN = 1'b1;
        bypass_cycles("r0", 3);
        DIV_RATIO = 8'd1;
        bypass_cycles("r1", 3);

        // R=6, reset pulsed one cycle into HIGH
        @(posedge CLK);
        #1;
        DIV_RATIO = 8'd6;
        phase("r6.l", 1'b0, 3, 1'b0);
        phase("r6.h", 1'b1, 1, 1'b0);
        #5;
        RST = 1'b1;
        #1;
        chk("mrst.act", DIV_ACTIVE, 1'b0);
        chk("mrst.tick", PERIOD_TICK, 1'b0);
        chk("mrst.clk", DIV_CLK, 1'b0);
        #1;
        RST = 1'b0;
        phase("r6b.l0", 1'b0, 3, 1'b0);
        phase("r6b.h0", 1'b1, 3, 1'b0);
        phase("r6b.l1", 1'b0, 3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
